// File: rtl/up_job_sched_if.sv
// up_job_sched_if: descriptor push, status and engine control signals of the job scheduler
interface up_job_sched_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int REG_SIZE_WIDTH = 16,
  parameter int QUEUE_DEPTH = 4,
  parameter int DONE_CNT_WIDTH = 8
);
  logic push_i;
  logic [AXI_ADDR_WIDTH-1:0] push_src_i;
  logic [AXI_ADDR_WIDTH-1:0] push_dst_i;
  logic [REG_SIZE_WIDTH-1:0] push_size_i;
  logic flush_i;
  logic int_en_i;
  logic done_ack_i;
  logic sts_clr_i;
  logic eng_busy_i;
  logic [AXI_ADDR_WIDTH-1:0] eng_src_o;
  logic [AXI_ADDR_WIDTH-1:0] eng_dst_o;
  logic [REG_SIZE_WIDTH-1:0] eng_size_o;
  logic eng_trigger_o;
  logic [$clog2(QUEUE_DEPTH):0] q_count_o;
  logic q_full_o;
  logic overflow_o;
  logic active_o;
  logic [DONE_CNT_WIDTH-1:0] done_cnt_o;
  logic irq_o;
  modport slave (
    input push_i, push_src_i, push_dst_i, push_size_i, flush_i, int_en_i,
          done_ack_i, sts_clr_i, eng_busy_i,
    output eng_src_o, eng_dst_o, eng_size_o, eng_trigger_o, q_count_o,
           q_full_o, overflow_o, active_o, done_cnt_o, irq_o
  );
  modport master (
    output push_i, push_src_i, push_dst_i, push_size_i, flush_i, int_en_i,
           done_ack_i, sts_clr_i, eng_busy_i,
    input eng_src_o, eng_dst_o, eng_size_o, eng_trigger_o, q_count_o,
          q_full_o, overflow_o, active_o, done_cnt_o, irq_o
  );
endinterface

// File: rtl/up_job_sched.sv
// up_job_sched: descriptor FIFO that launches copy jobs one at a time and counts completions
module up_job_sched #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int REG_SIZE_WIDTH = 16,
  parameter int QUEUE_DEPTH = 4,
  parameter int DONE_CNT_WIDTH = 8
) (
  input logic ACLK,
  input logic ARESETn,
  up_job_sched_if.slave bus
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] src_q [QUEUE_DEPTH];
  logic [AXI_ADDR_WIDTH-1:0] src_d [QUEUE_DEPTH];
  logic [AXI_ADDR_WIDTH-1:0] dst_q [QUEUE_DEPTH];
  logic [AXI_ADDR_WIDTH-1:0] dst_d [QUEUE_DEPTH];
  logic [REG_SIZE_WIDTH-1:0] size_q [QUEUE_DEPTH];
  logic [REG_SIZE_WIDTH-1:0] size_d [QUEUE_DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AXI_ADDR_WIDTH-1:0] eng_src_q, eng_src_d, eng_dst_q, eng_dst_d;
  logic [REG_SIZE_WIDTH-1:0] eng_size_q, eng_size_d;
  logic trig_q, trig_d, ovf_q, ovf_d;
  logic [DONE_CNT_WIDTH-1:0] done_q, done_d;
  logic full, pop, push_ok, in_flight;
  always_comb begin
    full = count_q == CW'(QUEUE_DEPTH);
    pop = state_q == WAIT_DONE && !bus.eng_busy_i;
    push_ok = bus.push_i && !bus.flush_i && (!full || pop);
    in_flight = state_q != IDLE && !pop;
    src_d = src_q;
    dst_d = dst_q;
    size_d = size_q;
    if (push_ok) begin
      src_d[tail_q] = bus.push_src_i;
      dst_d[tail_q] = bus.push_dst_i;
      size_d[tail_q] = bus.push_size_i;
    end
    head_d = pop ? head_q + AW'(1) : head_q;
    // a flush keeps only the job already handed to the engine
    tail_d = bus.flush_i ? head_d + AW'(in_flight) : push_ok ? tail_q + AW'(1) : tail_q;
    count_d = bus.flush_i ? CW'(in_flight) : count_q + CW'(push_ok) - CW'(pop);
    eng_src_d = count_d != '0 ? src_d[head_d] : eng_src_q;
    eng_dst_d = count_d != '0 ? dst_d[head_d] : eng_dst_q;
    eng_size_d = count_d != '0 ? size_d[head_d] : eng_size_q;
    state_d = state_q;
    unique case (state_q)
      IDLE: if (count_q != '0 && !bus.flush_i) state_d = LAUNCH;
      LAUNCH: state_d = WAIT_BUSY;
      WAIT_BUSY: if (bus.eng_busy_i) state_d = WAIT_DONE;
      default: if (!bus.eng_busy_i) state_d = IDLE;
    endcase
    trig_d = state_d == LAUNCH;
    ovf_d = (bus.push_i && !bus.flush_i && full && !pop) ? 1'b1 : bus.sts_clr_i ? 1'b0 : ovf_q;
    done_d = done_q;
    if (pop && !bus.done_ack_i && done_q != '1) done_d = done_q + DONE_CNT_WIDTH'(1);
    else if (!pop && bus.done_ack_i && done_q != '0) done_d = done_q - DONE_CNT_WIDTH'(1);
  end
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      state_q <= IDLE;
      src_q <= '{default: '0};
      dst_q <= '{default: '0};
      size_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      eng_src_q <= '0;
      eng_dst_q <= '0;
      eng_size_q <= '0;
      trig_q <= 1'b0;
      ovf_q <= 1'b0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      size_q <= size_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      eng_src_q <= eng_src_d;
      eng_dst_q <= eng_dst_d;
      eng_size_q <= eng_size_d;
      trig_q <= trig_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
    end
  assign bus.eng_src_o = eng_src_q;
  assign bus.eng_dst_o = eng_dst_q;
  assign bus.eng_size_o = eng_size_q;
  assign bus.eng_trigger_o = trig_q;
  assign bus.q_count_o = count_q;
  assign bus.q_full_o = full;
  assign bus.overflow_o = ovf_q;
  assign bus.active_o = state_q != IDLE;
  assign bus.done_cnt_o = done_q;
  assign bus.irq_o = bus.int_en_i && done_q != '0;
endmodule

// File: tb/tb_up_job_sched.sv
// tb_up_job_sched: directed vector table plus hand sequences for back-to-back, counters and reset
module tb_up_job_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  up_job_sched_if #(.DONE_CNT_WIDTH(2)) bus ();
  up_job_sched #(.DONE_CNT_WIDTH(2)) dut (.ACLK(clk), .ARESETn(rst_n), .bus(bus));
  typedef struct {
    logic push;
    logic [31:0] src;
    logic [31:0] dst;
    logic flush, ack, clr, busy;
    logic [2:0] cnt;
    logic trig, ovf;
    logic [1:0] done;
    logic irq, act;
    logic [31:0] esrc;
    logic [31:0] edst;
  } vec_t;
  vec_t vecs [23];
  function automatic vec_t mk(logic p, logic [31:0] s, logic [31:0] d, logic f, logic a, logic cl,
                              logic b, logic [2:0] cnt, logic t, logic o, logic [1:0] dn,
                              logic i, logic ac, logic [31:0] es, logic [31:0] ed);
    vec_t v;
    v.push = p; v.src = s; v.dst = d; v.flush = f; v.ack = a; v.clr = cl; v.busy = b;
    v.cnt = cnt; v.trig = t; v.ovf = o; v.done = dn; v.irq = i; v.act = ac; v.esrc = es; v.edst = ed;
    return v;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_job(input logic [31:0] s, input logic ack_at_done, input logic [1:0] exp_done);
    bus.push_i = 1'b1; bus.push_src_i = s; bus.push_dst_i = s + 32'h1; bus.push_size_i = 16'h20;
    step();
    bus.push_i = 1'b0;
    check("job_size", 64'(bus.eng_size_o), 64'h20);
    step();
    check("job_trig", 64'(bus.eng_trigger_o), 64'd1);
    bus.eng_busy_i = 1'b1;
    step();
    step();
    bus.eng_busy_i = 1'b0; bus.done_ack_i = ack_at_done;
    step();
    bus.done_ack_i = 1'b0;
    check("job_done", 64'(bus.done_cnt_o), 64'(exp_done));
  endtask
  initial begin
    int bc, trigs, last;
    logic [31:0] cs [3];
    {bus.push_i, bus.flush_i, bus.done_ack_i, bus.sts_clr_i, bus.eng_busy_i} = '0;
    bus.push_src_i = '0; bus.push_dst_i = '0; bus.push_size_i = '0; bus.int_en_i = 1'b1;
    vecs[0]  = mk(1, 32'h1000, 32'h2000, 0,0,0,0, 1,0,0,0,0,0, 32'h1000, 32'h2000);
    vecs[1]  = mk(0, 0, 0,               0,0,0,0, 1,1,0,0,0,1, 32'h1000, 32'h2000);
    vecs[2]  = mk(0, 0, 0,               0,0,0,0, 1,0,0,0,0,1, 32'h1000, 32'h2000);
    vecs[3]  = mk(0, 0, 0,               0,0,0,1, 1,0,0,0,0,1, 32'h1000, 32'h2000);
    vecs[4]  = mk(0, 0, 0,               0,0,0,1, 1,0,0,0,0,1, 32'h1000, 32'h2000);
    vecs[5]  = mk(0, 0, 0,               0,0,0,0, 0,0,0,1,1,0, 32'h1000, 32'h2000);
    vecs[6]  = mk(0, 0, 0,               0,1,0,0, 0,0,0,0,0,0, 32'h1000, 32'h2000);
    vecs[7]  = mk(0, 0, 0,               0,1,0,0, 0,0,0,0,0,0, 32'h1000, 32'h2000);
    vecs[8]  = mk(1, 32'hA000, 32'hB000, 0,0,0,0, 1,0,0,0,0,0, 32'hA000, 32'hB000);
    vecs[9]  = mk(1, 32'hA001, 32'hB001, 0,0,0,0, 2,1,0,0,0,1, 32'hA000, 32'hB000);
    vecs[10] = mk(1, 32'hA002, 32'hB002, 0,0,0,0, 3,0,0,0,0,1, 32'hA000, 32'hB000);
    vecs[11] = mk(1, 32'hA003, 32'hB003, 0,0,0,0, 4,0,0,0,0,1, 32'hA000, 32'hB000);
    vecs[12] = mk(1, 32'hA004, 32'hB004, 0,0,0,0, 4,0,1,0,0,1, 32'hA000, 32'hB000);
    vecs[13] = mk(0, 0, 0,               0,0,1,0, 4,0,0,0,0,1, 32'hA000, 32'hB000);
    vecs[14] = mk(0, 0, 0,               0,0,0,1, 4,0,0,0,0,1, 32'hA000, 32'hB000);
    vecs[15] = mk(1, 32'hA005, 32'hB005, 0,0,0,0, 4,0,0,1,1,0, 32'hA001, 32'hB001);
    vecs[16] = mk(0, 0, 0,               0,0,0,0, 4,1,0,1,1,1, 32'hA001, 32'hB001);
    vecs[17] = mk(0, 0, 0,               0,0,0,0, 4,0,0,1,1,1, 32'hA001, 32'hB001);
    vecs[18] = mk(0, 0, 0,               0,0,0,1, 4,0,0,1,1,1, 32'hA001, 32'hB001);
    vecs[19] = mk(1, 32'hC0DE, 32'hC0DE, 1,0,0,1, 1,0,0,1,1,1, 32'hA001, 32'hB001);
    vecs[20] = mk(0, 0, 0,               0,0,0,0, 0,0,0,2,1,0, 32'hA001, 32'hB001);
    vecs[21] = mk(0, 0, 0,               0,0,0,0, 0,0,0,2,1,0, 32'hA001, 32'hB001);
    vecs[22] = mk(0, 0, 0,               0,1,1,0, 0,0,0,1,1,0, 32'hA001, 32'hB001);
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(bus.q_count_o), 0);
    check("rst_trig", 64'(bus.eng_trigger_o), 0);
    check("rst_active", 64'(bus.active_o), 0);
    check("rst_src", 64'(bus.eng_src_o), 0);
    check("rst_irq", 64'(bus.irq_o), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 23; i++) begin
      bus.push_i = vecs[i].push; bus.push_src_i = vecs[i].src; bus.push_dst_i = vecs[i].dst;
      bus.push_size_i = 16'h10; bus.flush_i = vecs[i].flush; bus.done_ack_i = vecs[i].ack;
      bus.sts_clr_i = vecs[i].clr; bus.eng_busy_i = vecs[i].busy;
      step();
      check($sformatf("v%0d_count", i), 64'(bus.q_count_o), 64'(vecs[i].cnt));
      check($sformatf("v%0d_full", i), 64'(bus.q_full_o), 64'(vecs[i].cnt == 3'd4));
      check($sformatf("v%0d_trig", i), 64'(bus.eng_trigger_o), 64'(vecs[i].trig));
      check($sformatf("v%0d_ovf", i), 64'(bus.overflow_o), 64'(vecs[i].ovf));
      check($sformatf("v%0d_done", i), 64'(bus.done_cnt_o), 64'(vecs[i].done));
      check($sformatf("v%0d_irq", i), 64'(bus.irq_o), 64'(vecs[i].irq));
      check($sformatf("v%0d_active", i), 64'(bus.active_o), 64'(vecs[i].act));
      check($sformatf("v%0d_src", i), 64'(bus.eng_src_o), 64'(vecs[i].esrc));
      check($sformatf("v%0d_dst", i), 64'(bus.eng_dst_o), 64'(vecs[i].edst));
      if (i == 0) check("v0_size", 64'(bus.eng_size_o), 64'h10);
    end
    {bus.push_i, bus.flush_i, bus.done_ack_i, bus.sts_clr_i, bus.eng_busy_i} = '0;
    bus.done_ack_i = 1'b1;
    step();
    bus.done_ack_i = 1'b0;
    check("pre_b2b_done", 64'(bus.done_cnt_o), 0);
    cs[0] = 32'hC000; cs[1] = 32'hC100; cs[2] = 32'hC200;
    bc = 0; trigs = 0; last = 0;
    for (int c = 0; c < 40; c++) begin
      bus.push_i = c < 3;
      if (c < 3) begin
        bus.push_src_i = cs[c]; bus.push_dst_i = cs[c] + 32'h1;
      end
      step();
      bus.eng_busy_i = bc > 0;
      if (bc > 0) bc--;
      if (bus.eng_trigger_o) begin
        check("b2b_engine_idle", 64'(bus.eng_busy_i), 0);
        check("b2b_order", 64'(bus.eng_src_o), trigs < 3 ? 64'(cs[trigs]) : 64'hDEAD);
        if (trigs > 0) check("b2b_gap", 64'(c - last), 6);
        last = c; trigs++; bc = 3;
      end
    end
    bus.push_i = 1'b0; bus.eng_busy_i = 1'b0;
    check("b2b_triggers", 64'(trigs), 3);
    check("b2b_done", 64'(bus.done_cnt_o), 3);
    check("b2b_count", 64'(bus.q_count_o), 0);
    bus.done_ack_i = 1'b1;
    step();
    bus.done_ack_i = 1'b0;
    check("ack_dec", 64'(bus.done_cnt_o), 2);
    run_job(32'hD000, 1'b1, 2'd2);
    run_job(32'hD100, 1'b0, 2'd3);
    run_job(32'hD200, 1'b0, 2'd3);
    bus.int_en_i = 1'b0;
    #1;
    check("irq_masked", 64'(bus.irq_o), 0);
    bus.int_en_i = 1'b1;
    #1;
    check("irq_level", 64'(bus.irq_o), 1);
    bus.push_i = 1'b1; bus.push_src_i = 32'hE000; bus.push_dst_i = 32'hE001;
    step();
    bus.push_i = 1'b0;
    step();
    bus.eng_busy_i = 1'b1;
    step();
    step();
    check("mid_active", 64'(bus.active_o), 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_count", 64'(bus.q_count_o), 0);
    check("arst_active", 64'(bus.active_o), 0);
    check("arst_done", 64'(bus.done_cnt_o), 0);
    check("arst_irq", 64'(bus.irq_o), 0);
    check("arst_src", 64'(bus.eng_src_o), 0);
    check("arst_dst", 64'(bus.eng_dst_o), 0);
    check("arst_trig", 64'(bus.eng_trigger_o), 0);
    @(negedge clk);
    bus.eng_busy_i = 1'b0;
    rst_n = 1'b1;
    step();
    check("post_rst_active", 64'(bus.active_o), 0);
    check("post_rst_trig", 64'(bus.eng_trigger_o), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/up_job_sched.md
Name: up_job_sched

Overview:
- Descriptor-queue scheduler in front of the user-plugin AXI word-copy engine.
- Software pushes copy jobs (src, dst, size) into a small FIFO; the block launches them one at a time via the engine's trigger pulse, tracks busy, counts completions and raises a coalesced interrupt.
- Sits between the plugin register file and the copy engine. The engine's own interrupt is left unused when this block is present.

Parameters:
- AXI_ADDR_WIDTH, 32, width of src/dst byte addresses.
- REG_SIZE_WIDTH, 16, width of the byte-size field.
- QUEUE_DEPTH, 4, descriptor FIFO entries (power of 2, ≥2).
- DONE_CNT_WIDTH, 8, width of the completion counter.

Ports:
- ACLK  in  1  clock, rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- push_i  in  1  one-cycle pulse that enqueues a descriptor.
- push_src_i  in  AXI_ADDR_WIDTH  source byte address.
- push_dst_i  in  AXI_ADDR_WIDTH  destination byte address.
- push_size_i  in  REG_SIZE_WIDTH  byte size; passed through unmodified.
- flush_i  in  1  pulse; discards all queued descriptors that are not in flight.
- int_en_i  in  1  interrupt enable.
- done_ack_i  in  1  pulse; acknowledges one completion.
- sts_clr_i  in  1  pulse; clears the sticky overflow flag.
- eng_busy_i  in  1  engine status_busy.
- eng_src_o  out  AXI_ADDR_WIDTH  engine source address.
- eng_dst_o  out  AXI_ADDR_WIDTH  engine destination address.
- eng_size_o  out  REG_SIZE_WIDTH  engine size.
- eng_trigger_o  out  1  engine trigger pulse.
- q_count_o  out  $clog2(QUEUE_DEPTH)+1  number of queued entries, including the in-flight one.
- q_full_o  out  1  count == QUEUE_DEPTH.
- overflow_o  out  1  sticky; set when a push is dropped.
- active_o  out  1  state != IDLE.
- done_cnt_o  out  DONE_CNT_WIDTH  completions not yet acknowledged.
- irq_o  out  1  interrupt.

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; done_cnt = 0; overflow = 0.
- FIFO: registered, pointer-based, wraps modulo QUEUE_DEPTH. The head entry stays in the FIFO until its job completes.
- eng_src_o, eng_dst_o and eng_size_o always show the head entry. When empty they hold the last value; on reset they are 0.
- Push when not full: write at tail, count +1.
- Push when full: dropped and overflow set. Exception: if a pop happens in the same cycle, the push is accepted and count is unchanged.
- Simultaneous push and pop when not full: count unchanged.
- FSM states and transitions:
  - IDLE: if count != 0, go to LAUNCH.
  - LAUNCH: eng_trigger_o = 1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: if eng_busy_i = 1, go to WAIT_DONE. A job of ≥1 word holds busy for at least 3 cycles.
  - WAIT_DONE: if eng_busy_i = 0, pop the head, increment done_cnt and go to IDLE.
- Latency:
  - push in cycle N into an empty, idle queue → eng_trigger_o high in cycle N+2.
  - Back-to-back jobs: next trigger 2 cycles after the busy falling edge is sampled.
- Trigger is only issued in LAUNCH and the engine is never triggered while busy.
- flush_i:
  - Resets the tail to head+1 if the FSM is in LAUNCH, WAIT_BUSY or WAIT_DONE; otherwise resets tail to head. Count becomes 1 or 0 respectively.
  - The in-flight job completes normally.
  - A push in the same cycle as flush is dropped, and overflow is not set.
- done_cnt:
  - Saturates at all-ones and does not wrap.
  - done_ack_i decrements it, but not below 0.
  - Completion and ack in the same cycle: unchanged.
- irq_o = int_en_i & (done_cnt != 0). It is a level, combinational from registers.
- sts_clr_i clears overflow. If it coincides with an overflow event, the set wins.
- Reset asserted mid-job: everything returns to reset values immediately. The engine is reset by the same ARESETn.

Test Plan:
- Single job: push src=0x1000, dst=0x2000, size=16 with int_en=1 → trigger one cycle at N+2, eng_* show those values; busy rises then falls; done_cnt=1, irq_o=1; done_ack → done_cnt=0, irq_o=0.
- Fill and overflow, QUEUE_DEPTH=4: 5 pushes in consecutive cycles → count=4, q_full=1, overflow=1; the 5th descriptor is never launched; after sts_clr, overflow=0.
- Back-to-back: 3 queued jobs → exactly 3 trigger pulses, each only after busy has fallen; jobs run in FIFO order; done_cnt=3.
- Full-queue push coinciding with a completion pop → push accepted, count stays 4, overflow=0.
- Flush during job 1 with 3 queued → job 1 completes, count goes 3→1→0, no further triggers, done_cnt=1.
- Counters and reset: ack with done_cnt=0 → stays 0; completion and ack in the same cycle → unchanged; ARESETn low during WAIT_DONE → all outputs 0, state IDLE.
